// File: rtl/stall_bubble_reg.sv
// ID/EX boundary register with hazard bubble insertion and flush.
// Holds upstream via stall_out while a multi-cycle bubble train drains.
module stall_bubble_reg #(
  parameter int CTRL_W = 9,
  parameter int REG_W  = 5,
  parameter int NREG   = 2,
  parameter int CNT_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CTRL_W-1:0]     ctrl_in,
  input  logic [NREG*REG_W-1:0] regs_in,
  input  logic                  stall_req,
  input  logic [CNT_W-1:0]      stall_len,
  input  logic                  flush,
  output logic [CTRL_W-1:0]     ctrl_out,
  output logic [NREG*REG_W-1:0] regs_out,
  output logic                  bubble_out,
  output logic                  stall_out,
  output logic [15:0]           bubble_cnt
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  rem;
  logic [CNT_W-1:0]  rem_n;
  logic [CNT_W-1:0]  len_eff;
  logic              bubble;
  logic [15:0]       cnt;

  // A zero-length request still costs one bubble.
  assign len_eff = (stall_len == '0) ? CNT_W'(1) : stall_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      rem   <= '0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
    end
  end

  always_comb begin
    state_n = state;
    rem_n   = rem;
    bubble  = 1'b0;
    unique case (state)
      RUN: begin
        if (flush) begin
          bubble = 1'b1;
        end else if (stall_req) begin
          bubble = 1'b1;
          if (len_eff > CNT_W'(1)) begin
            state_n = STALL;
            rem_n   = len_eff - CNT_W'(1);
          end
        end
      end
      STALL: begin
        bubble = 1'b1;
        if (flush) begin
          state_n = RUN;
          rem_n   = '0;
        end else begin
          rem_n = rem - CNT_W'(1);
          if (rem == CNT_W'(1)) state_n = RUN;
        end
      end
      default: begin
        state_n = RUN;
        rem_n   = '0;
      end
    endcase
  end

  always_comb begin
    stall_out = 1'b0;
    unique case (state)
      RUN:     stall_out = stall_req & ~flush;
      STALL:   stall_out = 1'b1;
      default: stall_out = 1'b0;
    endcase
  end

  // Zeroed specifiers keep the hazard detector from re-firing on a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_out   <= '0;
      regs_out   <= '0;
      bubble_out <= 1'b1;
      cnt        <= '0;
    end else begin
      if (bubble) begin
        ctrl_out   <= '0;
        regs_out   <= '0;
        bubble_out <= 1'b1;
        if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      end else begin
        ctrl_out   <= ctrl_in;
        regs_out   <= regs_in;
        bubble_out <= 1'b0;
      end
    end
  end

  assign bubble_cnt = cnt;

endmodule

// File: tb/tb_stall_bubble_reg.sv
// Directed bench for stall_bubble_reg: pass-through, stalls, flush,
// priority, counter saturation and reset abandoning a stall.
module tb_stall_bubble_reg;

  logic        clk;
  logic        reset;
  logic [8:0]  ctrl_in;
  logic [9:0]  regs_in;
  logic        stall_req;
  logic [1:0]  stall_len;
  logic        flush;
  logic [8:0]  ctrl_out;
  logic [9:0]  regs_out;
  logic        bubble_out;
  logic        stall_out;
  logic [15:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  stall_bubble_reg dut (
    .clk        (clk),
    .reset      (reset),
    .ctrl_in    (ctrl_in),
    .regs_in    (regs_in),
    .stall_req  (stall_req),
    .stall_len  (stall_len),
    .flush      (flush),
    .ctrl_out   (ctrl_out),
    .regs_out   (regs_out),
    .bubble_out (bubble_out),
    .stall_out  (stall_out),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [8:0] c,
                         input logic [9:0] r, input logic b,
                         input logic [15:0] n);
    chk({tag, ".ctrl"}, 32'(ctrl_out), 32'(c));
    chk({tag, ".regs"}, 32'(regs_out), 32'(r));
    chk({tag, ".bub"},  32'(bubble_out), 32'(b));
    chk({tag, ".cnt"},  32'(bubble_cnt), 32'(n));
  endtask

  initial begin
    reset = 1'b1; ctrl_in = '0; regs_in = '0;
    stall_req = 1'b0; stall_len = '0; flush = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_out("reset", 9'h0, 10'h0, 1'b1, 16'd0);
    chk("reset.state", 32'(dut.state), 32'd0);
    reset = 1'b0;

    // pass-through
    ctrl_in = 9'h1A5; regs_in = 10'h0C3; #1;
    chk("pass.stall", 32'(stall_out), 32'd0);
    @(negedge clk);
    chk_out("pass", 9'h1A5, 10'h0C3, 1'b0, 16'd0);

    // load-use, one bubble
    stall_req = 1'b1; stall_len = 2'd1; #1;
    chk("lu.stall", 32'(stall_out), 32'd1);
    @(negedge clk);
    chk_out("lu", 9'h0, 10'h0, 1'b1, 16'd1);
    chk("lu.state", 32'(dut.state), 32'd0);
    stall_req = 1'b0; ctrl_in = 9'h0AA; regs_in = 10'h155; #1;
    chk("lu.stall_end", 32'(stall_out), 32'd0);
    @(negedge clk);
    chk_out("lu.pass", 9'h0AA, 10'h155, 1'b0, 16'd1);

    // three-cycle stall; stall_req held junk during STALL is ignored
    ctrl_in = 9'h1F0; regs_in = 10'h3FF;
    stall_req = 1'b1; stall_len = 2'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ms.stall", 32'(stall_out), 32'd1);
      @(negedge clk);
      chk_out("ms.bub", 9'h0, 10'h0, 1'b1, 16'(2 + i));
      if (i == 0) stall_len = 2'd2;
      if (i == 1) stall_req = 1'b0;
    end
    #1;
    chk("ms.stall_end", 32'(stall_out), 32'd0);
    @(negedge clk);
    chk_out("ms.pass", 9'h1F0, 10'h3FF, 1'b0, 16'd4);

    // flush on the second bubble cycle
    stall_req = 1'b1; stall_len = 2'd3;
    @(negedge clk);
    chk("fl.state1", 32'(dut.state), 32'd1);
    chk("fl.cnt1", 32'(bubble_cnt), 32'd5);
    stall_req = 1'b0; flush = 1'b1; #1;
    chk("fl.stall", 32'(stall_out), 32'd1);
    @(negedge clk);
    chk_out("fl.bub", 9'h0, 10'h0, 1'b1, 16'd6);
    chk("fl.state2", 32'(dut.state), 32'd0);
    flush = 1'b0; #1;
    chk("fl.stall_end", 32'(stall_out), 32'd0);
    @(negedge clk);
    chk_out("fl.pass", 9'h1F0, 10'h3FF, 1'b0, 16'd6);

    // stall_len=0 behaves as 1
    stall_req = 1'b1; stall_len = 2'd0; #1;
    chk("z.stall", 32'(stall_out), 32'd1);
    @(negedge clk);
    chk_out("z", 9'h0, 10'h0, 1'b1, 16'd7);
    chk("z.state", 32'(dut.state), 32'd0);

    // flush beats stall_req
    flush = 1'b1; stall_len = 2'd3; #1;
    chk("pri.stall", 32'(stall_out), 32'd0);
    @(negedge clk);
    chk_out("pri", 9'h0, 10'h0, 1'b1, 16'd8);
    chk("pri.state", 32'(dut.state), 32'd0);
    flush = 1'b0; stall_req = 1'b0;
    @(negedge clk);
    chk_out("pri.pass", 9'h1F0, 10'h3FF, 1'b0, 16'd8);

    // saturation from a preloaded count
    force dut.cnt = 16'hFFFE;
    #1;
    release dut.cnt;
    flush = 1'b1;
    @(negedge clk);
    chk("sat.1", 32'(bubble_cnt), 32'hFFFF);
    @(negedge clk);
    chk("sat.2", 32'(bubble_cnt), 32'hFFFF);
    @(negedge clk);
    chk("sat.3", 32'(bubble_cnt), 32'hFFFF);
    flush = 1'b0;

    // reset abandons an in-progress stall
    stall_req = 1'b1; stall_len = 2'd3;
    @(negedge clk);
    chk("rs.state1", 32'(dut.state), 32'd1);
    stall_req = 1'b0; ctrl_in = 9'h155; regs_in = 10'h2AA;
    reset = 1'b1;
    @(negedge clk);
    chk_out("rs", 9'h0, 10'h0, 1'b1, 16'd0);
    chk("rs.state2", 32'(dut.state), 32'd0);
    reset = 1'b0; #1;
    chk("rs.stall", 32'(stall_out), 32'd0);
    @(negedge clk);
    chk_out("rs.pass", 9'h155, 10'h2AA, 1'b0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stall_bubble_reg.md
STALL_BUBBLE_REG -- requirements
Module: stall_bubble_reg

Interface
REQ-001 SHALL provide parameter CTRL_W, default 9, meaning width of the control-signal bundle (RegDst, Jump, Branch, nBranch, MemWrite, MemToReg, ALUSrc, RegWrite, Halt).
REQ-002 SHALL provide parameter REG_W, default 5, meaning width of one register specifier.
REQ-003 SHALL provide parameter NREG, default 2, meaning number of register specifiers carried (rd, rt).
REQ-004 SHALL provide parameter CNT_W, default 2, meaning width of the stall-length field; maximum stall length is 2^CNT_W-1.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, with synchronous, active-high reset.
REQ-007 SHALL have port ctrl_in, input, CTRL_W, decoded control bundle from ID.
REQ-008 SHALL have port regs_in, input, NREG*REG_W, register specifiers from ID, with specifier 0 in the LSBs.
REQ-009 SHALL have port stall_req, input, 1, hazard request to insert bubbles.
REQ-010 SHALL have port stall_len, input, CNT_W, number of bubbles requested, sampled with stall_req.
REQ-011 SHALL have port flush, input, 1, squash request from branch/jump resolution.
REQ-012 SHALL have port ctrl_out, output, CTRL_W, registered control bundle to EX.
REQ-013 SHALL have port regs_out, output, NREG*REG_W, registered specifiers to EX.
REQ-014 SHALL have port bubble_out, output, 1, high when the registered output is a bubble.
REQ-015 SHALL have port stall_out, output, 1, combinational hold for PC and IF/ID registers.
REQ-016 SHALL have port bubble_cnt, output, 16, saturating count of inserted bubbles.

Function
REQ-017 SHALL implement a two-state FSM with states RUN and STALL and an internal remaining-bubble counter rem of width CNT_W.
REQ-018 SHALL, when inserting a bubble, register all-zero ctrl_out and all-zero regs_out and set bubble_out to 1, so that zeroed specifiers cannot retrigger the hazard.
REQ-019 SHALL, in RUN with flush=1, insert one bubble and remain in RUN regardless of stall_req; flush has the highest priority.
REQ-020 SHALL, in RUN with stall_req=1 and flush=0, insert one bubble and set the effective length L to stall_len, or to 1 when stall_len=0.
REQ-021 SHALL, in the case of REQ-020, go to STALL with rem=L-1 when L>1, and otherwise stay in RUN.
REQ-022 SHALL, in RUN with stall_req=0 and flush=0, register ctrl_in and regs_in unchanged and set bubble_out to 0.
REQ-023 SHALL, in STALL, insert one bubble per cycle and decrement rem, returning to RUN on the cycle in which rem=1.
REQ-024 SHALL ignore stall_req and stall_len while in STALL.
REQ-025 SHALL, on flush in STALL, insert a bubble, set rem to 0, and return to RUN on the next cycle.
REQ-026 SHALL drive stall_out=1 when (RUN and stall_req and not flush) or when in STALL, and 0 otherwise; total stall cycles therefore equal L.
REQ-027 SHALL increment bubble_cnt by 1 for every bubble inserted by REQ-019 through REQ-025, saturating at 16'hFFFF without wrapping.

Reset
REQ-028 SHALL, while reset=1 at a rising clk edge, set the state to RUN, rem to 0, ctrl_out and regs_out to 0, bubble_out to 1, and bubble_cnt to 0; reset takes priority over flush and stall.
REQ-029 SHALL abandon any in-progress stall on reset, with stall_out=0 on the first cycle after reset deasserts unless stall_req=1.
REQ-030 SHALL NOT count reset cycles in bubble_cnt.

Verification
REQ-031 SHALL cover pass-through: ctrl_in=9'h1A5, regs_in=10'h0C3, with no stall or flush -> next cycle ctrl_out=9'h1A5, regs_out=10'h0C3, bubble_out=0, bubble_cnt unchanged.
REQ-032 SHALL cover load-use: stall_req=1, stall_len=1 for one cycle -> exactly one zero bubble, stall_out high for 1 cycle, FSM stays in RUN, bubble_cnt +1.
REQ-033 SHALL cover a multi-cycle stall: stall_req=1, stall_len=3 -> three consecutive bubbles, stall_out high for exactly 3 cycles, the held instruction is passed on the 4th edge, bubble_cnt +3.
REQ-034 SHALL cover flush mid-stall: stall_len=3 and flush on the second bubble cycle -> the FSM is in RUN after that edge, stall_out=0 in the next cycle, and only 2 bubbles are counted.
REQ-035 SHALL cover the boundary and priority cases: stall_len=0 is treated as 1; simultaneous flush and stall_req gives one bubble and stall_out=0.
REQ-036 SHALL cover saturation and reset: bubble_cnt preloaded to 16'hFFFE by forcing two bubbles reads FFFF and stays there; reset asserted mid-STALL -> all outputs zero, bubble_out=1, state RUN.
